// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared timing, colour and snapshot definitions for the pong renderer
// Contents:
//   timing constants   default 640x480@60 raw-counter geometry (H_*, V_*, PIX_DIV)
//   object constants   ball, paddle and net sizes/positions
//   rgb12, COL_*       12-bit colour type and the palette
//   snap_t             per-frame latched copy of the game-state inputs
//   in_span            half-open range test on 11-bit zero-extended values
package pong_pkg;

    localparam int PIX_DIV     = 4;
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 784;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 515;

    localparam int BALL_SIZE = 8;
    localparam int PADDLE_W  = 8;
    localparam int PADDLE_H  = 64;
    localparam int PADDLE1_X = 160;
    localparam int PADDLE2_X = 768;
    localparam int NET_X     = 463;

    typedef logic [11:0] rgb12;

    localparam rgb12 COL_BALL = 12'hFFF;
    localparam rgb12 COL_P1   = 12'hF00;
    localparam rgb12 COL_P2   = 12'h00F;
    localparam rgb12 COL_NET  = 12'h888;
    localparam rgb12 COL_BG   = 12'h000;

    typedef struct packed {
        logic [9:0] ball_x;
        logic [8:0] ball_y;
        logic [8:0] p1_y;
        logic [8:0] p2_y;
    } snap_t;

    // 11 bits leave headroom so lo + len never wraps for any 10-bit edge.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel-rate divider and raster counters with raw sync/active terms
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   pix_en       one-clk strobe per pixel (div == PIX_DIV-1)
//   hcount       current column, 0..H_TOTAL-1
//   vcount       current line, 0..V_TOTAL-1
//   hsync_raw    unregistered active-low hsync for the current counter value
//   vsync_raw    unregistered active-low vsync for the current counter value
//   in_act       current counter value lies in the active region
//   frame_last   counters sit on the last pixel of the frame
module vga_sync_gen #(
    parameter int PIX_DIV     = pong_pkg::PIX_DIV,
    parameter int H_TOTAL     = pong_pkg::H_TOTAL,
    parameter int H_SYNC      = pong_pkg::H_SYNC,
    parameter int H_ACT_START = pong_pkg::H_ACT_START,
    parameter int H_ACT_END   = pong_pkg::H_ACT_END,
    parameter int V_TOTAL     = pong_pkg::V_TOTAL,
    parameter int V_SYNC      = pong_pkg::V_SYNC,
    parameter int V_ACT_START = pong_pkg::V_ACT_START,
    parameter int V_ACT_END   = pong_pkg::V_ACT_END
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       in_act,
    output logic       frame_last
);
    import pong_pkg::*;

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             h_last;
    logic             v_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_MAX) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign pix_en = (div == DIV_MAX);
    assign h_last = (hcount == 10'(H_TOTAL - 1));
    assign v_last = (vcount == 10'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hcount <= '0;
                vcount <= v_last ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    assign hsync_raw  = !(hcount < 10'(H_SYNC));
    assign vsync_raw  = !(vcount < 10'(V_SYNC));
    assign in_act     = (hcount >= 10'(H_ACT_START)) && (hcount < 10'(H_ACT_END)) &&
                        (vcount >= 10'(V_ACT_START)) && (vcount < 10'(V_ACT_END));
    assign frame_last = h_last && v_last;

endmodule

// File: rtl/pong_vga_renderer.sv
// rtl/pong_vga_renderer.sv - VGA renderer drawing ball, paddles and net from per-frame snapshots
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   ballX, ballY        ball top-left corner, raw counter coordinates
//   paddle1Y, paddle2Y  paddle top edges, raw counter coordinates
//   hsync, vsync        registered active-low sync
//   red, green, blue    registered 4-bit colour channels
//   active              registered active-region flag, aligned with rgb
//   frame_start         one-clk pulse following the input snapshot
module pong_vga_renderer #(
    parameter int PIX_DIV     = pong_pkg::PIX_DIV,
    parameter int H_TOTAL     = pong_pkg::H_TOTAL,
    parameter int H_SYNC      = pong_pkg::H_SYNC,
    parameter int H_ACT_START = pong_pkg::H_ACT_START,
    parameter int H_ACT_END   = pong_pkg::H_ACT_END,
    parameter int V_TOTAL     = pong_pkg::V_TOTAL,
    parameter int V_SYNC      = pong_pkg::V_SYNC,
    parameter int V_ACT_START = pong_pkg::V_ACT_START,
    parameter int V_ACT_END   = pong_pkg::V_ACT_END,
    parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
    parameter int PADDLE_W    = pong_pkg::PADDLE_W,
    parameter int PADDLE_H    = pong_pkg::PADDLE_H,
    parameter int PADDLE1_X   = pong_pkg::PADDLE1_X,
    parameter int PADDLE2_X   = pong_pkg::PADDLE2_X,
    parameter int NET_X       = pong_pkg::NET_X
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] ballX,
    input  logic [8:0] ballY,
    input  logic [8:0] paddle1Y,
    input  logic [8:0] paddle2Y,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       active,
    output logic       frame_start
);
    import pong_pkg::*;

    logic       pix_en;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       in_act;
    logic       frame_last;

    vga_sync_gen #(
        .PIX_DIV    (PIX_DIV),
        .H_TOTAL    (H_TOTAL),
        .H_SYNC     (H_SYNC),
        .H_ACT_START(H_ACT_START),
        .H_ACT_END  (H_ACT_END),
        .V_TOTAL    (V_TOTAL),
        .V_SYNC     (V_SYNC),
        .V_ACT_START(V_ACT_START),
        .V_ACT_END  (V_ACT_END)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .in_act    (in_act),
        .frame_last(frame_last)
    );

    // Snapshot on the last pixel of the frame: the counter wrap and the new
    // positions take effect together, so pixel (0,0) already uses them.
    snap_t snap;
    logic  take_snap;

    assign take_snap = pix_en && frame_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            snap        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= take_snap;
            if (take_snap) begin
                snap <= {ballX, ballY, paddle1Y, paddle2Y};
            end
        end
    end

    logic [10:0] h11;
    logic [10:0] v11;
    logic        hit_ball;
    logic        hit_p1;
    logic        hit_p2;
    logic        hit_net;

    assign h11 = {1'b0, hcount};
    assign v11 = {1'b0, vcount};

    assign hit_ball = in_span(h11, {1'b0, snap.ball_x}, 11'(BALL_SIZE)) &&
                      in_span(v11, {2'b0, snap.ball_y}, 11'(BALL_SIZE));
    assign hit_p1   = in_span(h11, 11'(PADDLE1_X), 11'(PADDLE_W)) &&
                      in_span(v11, {2'b0, snap.p1_y}, 11'(PADDLE_H));
    assign hit_p2   = in_span(h11, 11'(PADDLE2_X), 11'(PADDLE_W)) &&
                      in_span(v11, {2'b0, snap.p2_y}, 11'(PADDLE_H));
    // Bit 4 of the line counter alternates every 16 lines, giving the dashes.
    assign hit_net  = in_span(h11, 11'(NET_X), 11'd2) && !vcount[4];

    rgb12 pix;

    always_comb begin
        pix = COL_BG;
        if (in_act) begin
            if (hit_ball) begin
                pix = COL_BALL;
            end else if (hit_p1) begin
                pix = COL_P1;
            end else if (hit_p2) begin
                pix = COL_P2;
            end else if (hit_net) begin
                pix = COL_NET;
            end
        end
    end

    // All four pixel-describing outputs share one register stage so they
    // stay aligned one pixel behind the counters.
    rgb12 rgb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q  <= COL_BG;
            active <= 1'b0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
        end else if (pix_en) begin
            rgb_q  <= pix;
            active <= in_act;
            hsync  <= hsync_raw;
            vsync  <= vsync_raw;
        end
    end

    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];

endmodule
